// File: rtl/sr_command_generator_pkg.sv
// Shared types for the SR latch command generator: FSM states, pending-slot
// encodings and small elaboration-time helpers.
package sr_command_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE_S = 2'd1,
        ST_PULSE_R = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_SET  = 2'd1,
        PEND_RST  = 2'd2
    } pend_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic state_t pulse_state(input pend_t p);
        return (p == PEND_RST) ? ST_PULSE_R : ST_PULSE_S;
    endfunction

endpackage

// File: rtl/sr_command_generator_if.sv
// Button inputs and latch-drive outputs of the command generator, plus the
// FSM state for observation.
interface sr_command_generator_if;
    import sr_command_generator_pkg::*;

    logic   set_btn;
    logic   reset_btn;
    logic   S;
    logic   R;
    logic   busy;
    logic   conflict;
    state_t state_dbg;

    modport master (
        output set_btn, reset_btn,
        input  S, R, busy, conflict, state_dbg
    );

    modport slave (
        input  set_btn, reset_btn,
        output S, R, busy, conflict, state_dbg
    );

endinterface

// File: rtl/sr_command_generator_button_debouncer.sv
// Two-flop synchroniser followed by a run-length debouncer: the level only
// follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the run.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/sr_command_generator.sv
// Turns debounced set/reset presses into fixed-width, non-overlapping S/R
// pulses for an SR latch, with a single last-press-wins pending slot.
module sr_command_generator
    import sr_command_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 3,
    parameter int GAP_CYCLES      = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    sr_command_generator_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);

    logic             set_level, rst_level;
    logic             set_prev_q, set_prev_d;
    logic             rst_prev_q, rst_prev_d;
    logic             req_s_q, req_s_d;
    logic             req_r_q, req_r_d;
    state_t           state_q, state_d;
    pend_t            pend_q, pend_d;
    pend_t            new_req;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy_q, busy_d;
    logic             conflict_q, conflict_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (bus.set_btn),
        .btn_level (set_level)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (bus.reset_btn),
        .btn_level (rst_level)
    );

    always_comb begin
        set_prev_d = set_level;
        rst_prev_d = rst_level;
        req_s_d    = set_level & ~set_prev_q;
        req_r_d    = rst_level & ~rst_prev_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        conflict_d = req_s_q & req_r_q;
        new_req    = PEND_NONE;
        // Simultaneous requests cancel each other and leave the slot alone.
        if (req_s_q && !req_r_q) begin
            new_req = PEND_SET;
        end else if (req_r_q && !req_s_q) begin
            new_req = PEND_RST;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pend_q != PEND_NONE) begin
                    state_d = pulse_state(pend_q);
                    pend_d  = new_req;
                end else if (new_req != PEND_NONE) begin
                    state_d = pulse_state(new_req);
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (new_req != PEND_NONE) begin
                    pend_d = new_req;
                end
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (new_req != PEND_NONE) begin
                    pend_d = new_req;
                end
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    // A request landing on this last gap cycle waits in the slot.
                    if (pend_q != PEND_NONE) begin
                        state_d = pulse_state(pend_q);
                        pend_d  = new_req;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_d    = (state_d == ST_PULSE_S);
        r_d    = (state_d == ST_PULSE_R);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_prev_q <= 1'b0;
            rst_prev_q <= 1'b0;
            req_s_q    <= 1'b0;
            req_r_q    <= 1'b0;
            state_q    <= ST_IDLE;
            pend_q     <= PEND_NONE;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            set_prev_q <= set_prev_d;
            rst_prev_q <= rst_prev_d;
            req_s_q    <= req_s_d;
            req_r_q    <= req_r_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.R         = r_q;
    assign bus.busy      = busy_q;
    assign bus.conflict  = conflict_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/sr_command_generator.md
Name: sr_command_generator

Overview:
- Sequential front end that sits directly upstream of the unclocked SR latch and drives its S and R inputs.
- Takes two raw, bouncy pushbuttons (set, reset) and synchronises and debounces each one.
- Converts each press into a clean, fixed-width pulse on S or R.
- Guarantees the latch never sees S=R=1 (its forbidden input) and never sees overlapping or back-to-back pulses.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes (≥1).
- PULSE_CYCLES, 3: clock cycles S or R is held high per command (≥1).
- GAP_CYCLES, 2: minimum cycles with S=R=0 after every pulse (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_btn  in  1  raw asynchronous set pushbutton, active-high.
- reset_btn  in  1  raw asynchronous reset pushbutton, active-high.
- S  out  1  set drive to SR latch, registered.
- R  out  1  reset drive to SR latch, registered.
- busy  out  1  high in PULSE_S, PULSE_R or GAP.
- conflict  out  1  one-cycle pulse when set and reset presses are detected in the same cycle.

Behaviour:
- Reset (rst_n=0, async, takes effect immediately, including mid-pulse):
  - S=0, R=0, busy=0, conflict=0.
  - Synchroniser flops, debounced levels and edge-detect history cleared to 0.
  - Counters cleared; pending slot empty; FSM in IDLE.
- Synchroniser: two flops per button.
- Debouncer (per button):
  - Counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever the synchronised input equals the current debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the debounced level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the debounced level.
- Edge detect:
  - Registered rising edge of each debounced level gives req_s or req_r, one cycle wide.
  - Release (falling edge) produces nothing.
- Latency: with the button steady high, S (or R) is first high DEBOUNCE_CYCLES+4 rising edges after the first edge that samples it high. At defaults this is 8.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP. Outputs S and R are registered from the next state.
  - IDLE:
    - req_s alone → PULSE_S.
    - req_r alone → PULSE_R.
    - Pending slot holds a request → matching PULSE state; slot clears.
  - PULSE_S / PULSE_R:
    - S (resp. R) high for exactly PULSE_CYCLES cycles, then → GAP.
  - GAP:
    - S=R=0 for exactly GAP_CYCLES cycles.
    - Then → IDLE, or directly into the PULSE state for a pending request.
- Pending slot:
  - Single entry.
  - A request arriving in PULSE or GAP is stored; a newer request overwrites an older one (last press wins).
- Simultaneous events:
  - req_s and req_r in the same cycle, in any state: both dropped, pending slot unchanged, conflict=1 for that cycle.
  - A request that arrives in the same cycle as IDLE consuming the pending slot is stored as the new pending request.
- Invariants:
  - S & R is never 1.
  - Each press produces at most one pulse.
  - The pulse counter uses width $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1) and is shared between PULSE and GAP.

Decomposition:
- Shared header file (sr_cmd_defs.vh) holds:
  - FSM state encodings (IDLE=2'd0, PULSE_S=2'd1, PULSE_R=2'd2, GAP=2'd3).
  - Pending-slot encodings (NONE, SET, RST).
- One natural sub-module, button_debouncer (params DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, btn_level).
  - Contains the 2-flop synchroniser and the debounce counter.
  - Instantiated twice.
- Edge detect, arbitration and FSM stay in the top module.

Test Plan:
- Clean set press: set_btn 1 for 20 cycles → S=1 for cycles 8–10 after the press, then S=0; busy high for 5 cycles; R stays 0 throughout.
- Bounce rejection: set_btn toggled every cycle for 10 cycles, then 0 → S never asserts, busy stays 0.
- Back-to-back: clean set press, then a reset press that debounces while PULSE_S is active → S pulse of 3 cycles, 2 gap cycles, then R=1 for 3 cycles; S&R never 1.
- Simultaneous: set_btn and reset_btn rise on the same edge, both held 20 cycles → conflict=1 for one cycle, S=R=0, busy=0.
- Overwrite: set press, then reset press during PULSE_S, then set press during GAP → after GAP only an S pulse is issued; no R pulse.
- Reset mid-pulse: rst_n driven 0 in the 2nd cycle of PULSE_S → S drops to 0 immediately, without waiting for a clock edge. After release, S stays 0 with set_btn still held, because the debounced level was cleared and must re-qualify, giving a new pulse 8 cycles after release.
